n_majority_voter: RTL
=====================

# n_majority_voter

Parametrised, registered N-channel bitwise majority voter for redundant datapaths (TMR/NMR). Each valid sample of N words is voted bit by bit over the currently trusted channels, and the result is registered. The block tracks per-channel consecutive disagreements and masks a channel that disagrees too often, so later votes exclude it. It sits between redundant producer copies and the single downstream consumer, and exposes fault status for supervisory logic.

## Interface
- N, default 5: channel count, 3..15.
- W, default 8: data width per channel.
- FAULT_LIMIT, default 4: consecutive disagreements that mask a channel, 1..255.
- clk  in  1: sole clock, rising edge.
- rst_n  in  1: asynchronous active-low reset.
- in_valid  in  1: in_data holds a sample this cycle.
- in_data  in  N*W: channel k occupies bits [k*W+W-1 : k*W].
- clear_mask  in  1: single-cycle pulse that clears all masks and counters.
- vote_valid  out  1: registered; high for one cycle per voted sample.
- vote_data  out  W: registered voted word.
- vote_tie  out  1: at least one bit of the last sample was a tie.
- vote_fail  out  1: last sample had no active channel.
- disagree  out  N: bit k set if channel k was active and differed from vote_data on the last sample.
- fault_mask  out  N: bit k set means channel k is excluded from voting.

## Operation
- Active set: A = N − popcount(fault_mask), using the mask value before the current edge.
- Per bit b, ones = the count of active channels with bit b = 1.
  - ones*2 > A gives 1.
  - ones*2 < A gives 0.
  - ones*2 == A (tie, A even, A > 0) gives 0 and sets vote_tie.
- A == 0:
  - vote_data = 0 and vote_fail = 1.
  - disagree = 0; counters and mask hold.
- Disagreement: channel k is active and its word != the combinational vote result (full W-bit compare).
- Counters: one per channel, $clog2(FAULT_LIMIT+1) bits, updated only on in_valid.
  - An active, disagreeing channel increments, saturating at FAULT_LIMIT.
  - An active, agreeing channel resets to 0.
  - A masked channel holds.
- Mask set: fault_mask[k] is set on the same edge that counter k reaches FAULT_LIMIT.
  - The mask applies from the next sample on.
  - A mask stays set until clear_mask or reset.
- clear_mask:
  - Clears fault_mask and all counters on the next edge.
  - Dominates any counter update or mask set on that edge.
  - A sample accepted in the same cycle is voted with the old mask.
- in_valid low:
  - vote_valid = 0.
  - vote_data, vote_tie, vote_fail and disagree hold their last values.
  - Counters and mask hold.
- Inputs are not buffered. There is no backpressure: every in_valid cycle is one sample.

## Timing
- Latency is 1 cycle: a sample at edge t appears on vote_* and disagree after edge t, with vote_valid high for that cycle.
- Throughput is one sample per cycle.
- fault_mask is registered and reflects the counter update of the same edge.
- The combinational path is popcount plus compare over N channels.
- Reset (asynchronous, at any time, including mid-stream) forces all of the following to 0: vote_valid, vote_data, vote_tie, vote_fail, disagree, fault_mask, and every counter. The first sample after reset release is voted over all N channels.

## Test plan
- Reset and agreement, N=5, W=8:
  - During reset, all outputs are 0.
  - Drive all channels 0xA5 for one cycle. The next cycle gives vote_valid=1, vote_data=0xA5, disagree=0, tie=0, fail=0.
- Single stuck channel, FAULT_LIMIT=4:
  - Channel 2 = 0x00, others = 0x3C, for 4 valid cycles.
  - vote_data = 0x3C each time and disagree = 5'b00100.
  - fault_mask[2] rises after the 4th edge; on the 5th sample disagree = 0.
- Tie after masking:
  - With channel 2 masked (A=4), drive ch0=ch1=0xFF and ch3=ch4=0x00.
  - vote_data=0x00, vote_tie=1, disagree=5'b00011.
- Intermittent fault:
  - Channel 4 disagrees 3 times, agrees once, then disagrees 3 times.
  - fault_mask stays 0 throughout; the counter resets on the agreement.
- clear_mask with in_valid:
  - Assert both in the same cycle while channel 2 is masked.
  - That sample excludes channel 2; afterwards fault_mask=0 and the counters are 0.
- All masked, then reset mid-stream:
  - Set N=3, FAULT_LIMIT=1. Make channels disagree so that all three become masked; the next sample gives vote_fail=1 and vote_data=0.
  - Assert rst_n=0 mid-stream: all outputs and counters go to 0 immediately (asynchronously).

Source files
------------

// File: rtl/n_majority_voter.sv
// Registered N-channel bitwise majority voter with per-channel
// disagreement tracking and automatic masking of faulty channels.
module n_majority_voter #(
    parameter int N           = 5,
    parameter int W           = 8,
    parameter int FAULT_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [N*W-1:0]   in_data,
    input  logic             clear_mask,
    output logic             vote_valid,
    output logic [W-1:0]     vote_data,
    output logic             vote_tie,
    output logic             vote_fail,
    output logic [N-1:0]     disagree,
    output logic [N-1:0]     fault_mask
);

    localparam int CW = $clog2(N + 1) + 1;
    localparam int FW = $clog2(FAULT_LIMIT + 1);
    localparam logic [FW-1:0] LIMIT = FW'(FAULT_LIMIT);

    if (N < 3 || N > 15) begin : g_bad_n
        $error("n_majority_voter: N out of range");
    end
    if (FAULT_LIMIT < 1 || FAULT_LIMIT > 255) begin : g_bad_limit
        $error("n_majority_voter: FAULT_LIMIT out of range");
    end

    logic [W-1:0]         word [N];
    logic [CW-1:0]        active_cnt;
    logic [CW-1:0]        ones;
    logic [CW-1:0]        twice;
    logic [W-1:0]         vote_comb;
    logic [W-1:0]         tie_bits;
    logic                 fail_comb;
    logic [N-1:0]         dis_comb;
    logic [N-1:0][FW-1:0] cnt;
    logic [N-1:0][FW-1:0] cnt_next;
    logic [N-1:0]         mask_next;

    for (genvar k = 0; k < N; k++) begin : g_word
        assign word[k] = in_data[k*W +: W];
    end

    always_comb begin
        active_cnt = '0;
        for (int k = 0; k < N; k++) begin
            if (!fault_mask[k]) begin
                active_cnt = active_cnt + CW'(1);
            end
        end
    end

    assign fail_comb = (active_cnt == '0);

    // Compare 2*ones against the active count to avoid a division.
    always_comb begin
        vote_comb = '0;
        tie_bits  = '0;
        ones      = '0;
        twice     = '0;
        for (int b = 0; b < W; b++) begin
            ones = '0;
            for (int k = 0; k < N; k++) begin
                if (!fault_mask[k] && word[k][b]) begin
                    ones = ones + CW'(1);
                end
            end
            twice = ones << 1;
            if (twice > active_cnt) begin
                vote_comb[b] = 1'b1;
            end else if (twice == active_cnt && !fail_comb) begin
                tie_bits[b] = 1'b1;
            end
        end
    end

    always_comb begin
        dis_comb = '0;
        for (int k = 0; k < N; k++) begin
            dis_comb[k] = !fault_mask[k] && (word[k] != vote_comb);
        end
    end

    // A channel is masked on the same edge its counter hits the limit.
    always_comb begin
        cnt_next  = cnt;
        mask_next = fault_mask;
        for (int k = 0; k < N; k++) begin
            if (in_valid && !fault_mask[k]) begin
                if (dis_comb[k]) begin
                    if (cnt[k] != LIMIT) begin
                        cnt_next[k] = cnt[k] + FW'(1);
                    end
                end else begin
                    cnt_next[k] = '0;
                end
                if (cnt_next[k] == LIMIT) begin
                    mask_next[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            fault_mask <= '0;
        end else if (clear_mask) begin
            cnt        <= '0;
            fault_mask <= '0;
        end else begin
            cnt        <= cnt_next;
            fault_mask <= mask_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_valid <= 1'b0;
            vote_data  <= '0;
            vote_tie   <= 1'b0;
            vote_fail  <= 1'b0;
            disagree   <= '0;
        end else begin
            vote_valid <= in_valid;
            if (in_valid) begin
                vote_data <= vote_comb;
                vote_tie  <= |tie_bits;
                vote_fail <= fail_comb;
                disagree  <= dis_comb;
            end
        end
    end

endmodule
